// File: rtl/i2c_target.sv
// I2C target engine: 7-bit address match, write bytes out on rx_*, read bytes in on tx_*.
// Define I2C_TARGET_STRETCH_EN to stretch SCL instead of NACKing/underrunning.
module i2c_target #(
    parameter int DATA_BITS   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 arst_n,
    input  logic [6:0]           own_addr,
    input  logic                 scl_i,
    input  logic                 sda_i,
    output logic                 sda_oe,
    output logic                 scl_oe,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_pop,
    output logic                 busy,
    output logic                 addressed,
    output logic                 rd_mode,
    output logic                 rx_overrun,
    output logic                 tx_underrun
);
    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_ADDR      = 3'd1;
    localparam logic [2:0] S_ADDR_ACK  = 3'd2;
    localparam logic [2:0] S_WR_DATA   = 3'd3;
    localparam logic [2:0] S_WR_ACK    = 3'd4;
    localparam logic [2:0] S_RD_DATA   = 3'd5;
    localparam logic [2:0] S_RD_ACK    = 3'd6;
    localparam logic [2:0] S_WAIT_STOP = 3'd7;
    localparam logic [2:0] LAST_BIT    = 3'(DATA_BITS - 1);

    logic [SYNC_STAGES-1:0] r_scl_sync, r_sda_sync;
    logic                   r_scl_d, r_sda_d;
    logic [2:0]             r_state, r_bitcnt;
    logic [DATA_BITS-1:0]   r_shift;
    logic                   r_ack_drv;
`ifdef I2C_TARGET_STRETCH_EN
    logic                   r_stall;
`endif

    logic w_scl, w_sda, w_scl_rise, w_scl_fall, w_start, w_stop, w_rd_load;
    logic [DATA_BITS-1:0] w_rx_byte;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_d    <= 1'b1;
            r_sda_d    <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl_i};
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_i};
            r_scl_d    <= w_scl;
            r_sda_d    <= w_sda;
        end
    end

    assign w_scl      = r_scl_sync[SYNC_STAGES-1];
    assign w_sda      = r_sda_sync[SYNC_STAGES-1];
    assign w_scl_rise = w_scl & ~r_scl_d;
    assign w_scl_fall = ~w_scl & r_scl_d;
    assign w_start    = w_scl & r_scl_d & r_sda_d & ~w_sda;
    assign w_stop     = w_scl & r_scl_d & ~r_sda_d & w_sda;
    assign w_rx_byte  = {r_shift[DATA_BITS-2:0], w_sda};
    // Fall that ends an ACK clock and starts a read byte (first byte or after master ACK).
    assign w_rd_load  = w_scl_fall & r_ack_drv &
                        (((r_state == S_ADDR_ACK) & rd_mode) | (r_state == S_RD_ACK));

`ifndef I2C_TARGET_STRETCH_EN
    assign scl_oe = 1'b0;
`endif

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state     <= S_IDLE;
            r_bitcnt    <= '0;
            r_shift     <= '0;
            r_ack_drv   <= 1'b0;
            sda_oe      <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            tx_pop      <= 1'b0;
            busy        <= 1'b0;
            addressed   <= 1'b0;
            rd_mode     <= 1'b0;
            rx_overrun  <= 1'b0;
            tx_underrun <= 1'b0;
`ifdef I2C_TARGET_STRETCH_EN
            scl_oe      <= 1'b0;
            r_stall     <= 1'b0;
`endif
        end else begin
            tx_pop      <= 1'b0;
            rx_overrun  <= 1'b0;
            tx_underrun <= 1'b0;
            if (w_start) begin
                r_state  <= S_ADDR;
                r_bitcnt <= '0;
                sda_oe   <= 1'b0;
                rx_valid <= 1'b0;
                busy     <= 1'b1;
`ifdef I2C_TARGET_STRETCH_EN
                scl_oe   <= 1'b0;
                r_stall  <= 1'b0;
`endif
            end else if (w_stop) begin
                r_state   <= S_IDLE;
                sda_oe    <= 1'b0;
                rx_valid  <= 1'b0;
                busy      <= 1'b0;
                addressed <= 1'b0;
                rd_mode   <= 1'b0;
`ifdef I2C_TARGET_STRETCH_EN
                scl_oe    <= 1'b0;
                r_stall   <= 1'b0;
`endif
            end else begin
                case (r_state)
                    S_ADDR: if (w_scl_rise) begin
                        r_shift  <= w_rx_byte;
                        r_bitcnt <= r_bitcnt + 3'd1;
                        if (r_bitcnt == LAST_BIT) begin
                            r_ack_drv <= 1'b0;
                            if (r_shift[6:0] == own_addr) begin
                                r_state   <= S_ADDR_ACK;
                                addressed <= 1'b1;
                                rd_mode   <= w_sda;
                            end else begin
                                r_state   <= S_WAIT_STOP;
                                addressed <= 1'b0;
                                rd_mode   <= 1'b0;
                            end
                        end
                    end
                    // First fall pulls SDA for the ACK clock, second fall ends it.
                    S_ADDR_ACK, S_WR_ACK: if (w_scl_fall) begin
                        if (!r_ack_drv) begin
                            sda_oe    <= 1'b1;
                            r_ack_drv <= 1'b1;
                        end else begin
                            sda_oe   <= 1'b0;
                            r_bitcnt <= '0;
                            r_state  <= ((r_state == S_ADDR_ACK) && rd_mode) ? S_RD_DATA : S_WR_DATA;
                        end
                    end
                    S_WR_DATA: begin
                        if (rx_valid) begin
`ifdef I2C_TARGET_STRETCH_EN
                            if (rx_ready) begin
                                rx_valid <= 1'b0;
                                r_state  <= S_WR_ACK;
                                if (scl_oe || w_scl_fall) begin
                                    sda_oe    <= 1'b1;
                                    scl_oe    <= 1'b0;
                                    r_ack_drv <= 1'b1;
                                end else begin
                                    r_ack_drv <= 1'b0;
                                end
                            end else if (w_scl_fall) begin
                                scl_oe <= 1'b1;
                            end
`else
                            rx_valid  <= 1'b0;
                            r_ack_drv <= 1'b0;
                            if (rx_ready) begin
                                r_state <= S_WR_ACK;
                            end else begin
                                rx_overrun <= 1'b1;
                                r_state    <= S_WAIT_STOP;
                            end
`endif
                        end else if (w_scl_rise) begin
                            r_shift  <= w_rx_byte;
                            r_bitcnt <= r_bitcnt + 3'd1;
                            if (r_bitcnt == LAST_BIT) begin
                                rx_data  <= w_rx_byte;
                                rx_valid <= 1'b1;
                            end
                        end
                    end
                    S_RD_DATA:
`ifdef I2C_TARGET_STRETCH_EN
                        if (r_stall) begin
                            if (tx_valid) begin
                                r_shift <= tx_data;
                                tx_pop  <= 1'b1;
                                sda_oe  <= ~tx_data[DATA_BITS-1];
                                scl_oe  <= 1'b0;
                                r_stall <= 1'b0;
                            end
                        end else
`endif
                        if (w_scl_fall) begin
                            r_bitcnt <= r_bitcnt + 3'd1;
                            if (r_bitcnt == LAST_BIT) begin
                                sda_oe    <= 1'b0;
                                r_ack_drv <= 1'b0;
                                r_state   <= S_RD_ACK;
                            end else begin
                                sda_oe  <= ~r_shift[DATA_BITS-2];
                                r_shift <= r_shift << 1;
                            end
                        end
                    S_RD_ACK: begin
                        if (w_scl_rise) begin
                            if (w_sda) r_state   <= S_WAIT_STOP;
                            else       r_ack_drv <= 1'b1;
                        end else if (w_scl_fall && r_ack_drv) begin
                            r_state  <= S_RD_DATA;
                            r_bitcnt <= '0;
                        end
                    end
                    default: ;
                endcase
                if (w_rd_load) begin
                    if (tx_valid) begin
                        r_shift <= tx_data;
                        tx_pop  <= 1'b1;
                        sda_oe  <= ~tx_data[DATA_BITS-1];
                    end else begin
`ifdef I2C_TARGET_STRETCH_EN
                        r_stall <= 1'b1;
                        scl_oe  <= 1'b1;
                        sda_oe  <= 1'b0;
`else
                        r_shift     <= '1;
                        tx_underrun <= 1'b1;
                        sda_oe      <= 1'b0;
`endif
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: behavioural I2C master, bus/stream scoreboards, directed + random transfers.
module tb_i2c_target;
    localparam int Q = 12;

    logic       clk = 1'b0;
    logic       arst_n = 1'b0;
    logic [6:0] own_addr = 7'h50;
    logic       m_scl_low = 1'b0, m_sda_low = 1'b0;
    logic       rx_ready = 1'b1, tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       sda_oe, scl_oe, rx_valid, tx_pop, busy, addressed, rd_mode, rx_overrun, tx_underrun;
    logic [7:0] rx_data;
    logic       bus_scl, bus_sda;

    always #5 clk = ~clk;
    assign bus_scl = ~(m_scl_low | scl_oe);
    assign bus_sda = ~(m_sda_low | sda_oe);

    i2c_target #(.DATA_BITS(8), .SYNC_STAGES(2)) dut (
        .clk(clk), .arst_n(arst_n), .own_addr(own_addr),
        .scl_i(bus_scl), .sda_i(bus_sda), .sda_oe(sda_oe), .scl_oe(scl_oe),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_pop(tx_pop),
        .busy(busy), .addressed(addressed), .rd_mode(rd_mode),
        .rx_overrun(rx_overrun), .tx_underrun(tx_underrun)
    );

    int n_cmp = 0, n_bad = 0;
    logic [8:0] exp_bus[$];   // {byte, ack bit} as seen on the wire
    logic [7:0] exp_rx[$];
    int exp_pop = 0, exp_und = 0, exp_ovr = 0;
    int got_pop = 0, got_und = 0, got_ovr = 0;
    logic [7:0] dbuf[8];
    bit         rdy[8], txv[8];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    // Monitor: stream scoreboard, pulse counters, and a bus sniffer rebuilding 9-bit frames.
    logic p_scl = 1'b1, p_sda = 1'b1, p_oe = 1'b0;
    int   nbits = 0;
    logic [8:0] sh = '0;
    always @(negedge clk) begin
        p_scl <= bus_scl;
        p_sda <= bus_sda;
        p_oe  <= sda_oe;
        if (arst_n) begin
            if (rx_valid) begin
                if (exp_rx.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL rx_unexpected: got %0h want none", rx_data);
                end else check("rx_data", rx_data, exp_rx.pop_front());
            end
            if (tx_pop)      got_pop <= got_pop + 1;
            if (tx_underrun) got_und <= got_und + 1;
            if (rx_overrun)  got_ovr <= got_ovr + 1;
            if (sda_oe !== p_oe) check("sda_oe_change_scl_low", bus_scl, 1'b0);
            if (bus_scl && p_scl && (bus_sda !== p_sda)) nbits <= 0;
            else if (bus_scl && !p_scl) begin
                sh <= {sh[7:0], bus_sda};
                if (nbits == 8) begin
                    nbits <= 0;
                    if (exp_bus.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL bus_unexpected: got %0h want none", {sh[7:0], bus_sda});
                    end else check("bus_frame", {sh[7:0], bus_sda}, exp_bus.pop_front());
                end else nbits <= nbits + 1;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic m_start;
        m_sda_low = 1'b0; tick(Q);
        m_scl_low = 1'b0; tick(Q);
        m_sda_low = 1'b1; tick(Q);
        m_scl_low = 1'b1; tick(Q);
    endtask

    task automatic m_stop;
        m_sda_low = 1'b1; tick(Q);
        m_scl_low = 1'b0; tick(Q);
        m_sda_low = 1'b0; tick(Q);
    endtask

    task automatic m_wbit(input logic b);
        m_sda_low = ~b;   tick(Q);
        m_scl_low = 1'b0; tick(Q);
        m_scl_low = 1'b1; tick(Q);
    endtask

    task automatic m_rbit(output logic b);
        m_sda_low = 1'b0; tick(Q);
        m_scl_low = 1'b0; tick(Q / 2);
        b = bus_sda;      tick(Q / 2);
        m_scl_low = 1'b1; tick(Q);
    endtask

    task automatic m_wbyte(input logic [7:0] d);
        for (int i = 7; i >= 0; i--) m_wbit(d[i]);
    endtask

    task automatic m_rbyte;
        logic b;
        for (int i = 0; i < 8; i++) m_rbit(b);
    endtask

    task automatic chk_counts(input string tag);
        check({tag, "_tx_pop"}, got_pop, exp_pop);
        check({tag, "_tx_underrun"}, got_und, exp_und);
        check({tag, "_rx_overrun"}, got_ovr, exp_ovr);
    endtask

    // One transfer with n data bytes from dbuf/rdy/txv; the model decides ACKs and bus bytes.
    task automatic xfer(input logic [6:0] a, input bit rw, input int n, input bit do_stop);
        bit         hit;
        logic [7:0] eb;
        logic       ab;
        hit = (a == own_addr);
        if (rw) begin tx_valid = txv[0]; tx_data = dbuf[0]; end
        rx_ready = 1'b1;
        exp_bus.push_back({a, rw, ~hit});
        m_start;
        m_wbyte({a, rw});
        m_rbit(ab);
        check("busy_in_xfer", busy, 1'b1);
        check("addressed", addressed, hit);
        check("rd_mode", rd_mode, hit & rw);
        for (int i = 0; i < n; i++) begin
            if (!rw) begin
                rx_ready = rdy[i];
                exp_bus.push_back({dbuf[i], ~(hit & rdy[i])});
                if (hit) exp_rx.push_back(dbuf[i]);
                if (hit && !rdy[i]) exp_ovr++;
                m_wbyte(dbuf[i]);
                m_rbit(ab);
                hit = hit & rdy[i];
            end else begin
                eb = (hit && txv[i]) ? dbuf[i] : 8'hFF;
                if (hit) begin
                    if (txv[i]) exp_pop++;
                    else        exp_und++;
                end
                exp_bus.push_back({eb, i == n - 1});
                m_rbyte;
                if (i + 1 < n) begin tx_valid = txv[i+1]; tx_data = dbuf[i+1]; end
                m_wbit(i == n - 1);
            end
        end
        rx_ready = 1'b1;
        tx_valid = 1'b0;
        if (do_stop) begin
            m_stop;
            tick(4);
            check("busy_after_stop", busy, 1'b0);
            check("addressed_after_stop", addressed, 1'b0);
            check("rd_mode_after_stop", rd_mode, 1'b0);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic ab;
        logic [6:0] a;
        bit rw, st;
        int n;
        tick(3);
        check("reset_outputs",
              {sda_oe, scl_oe, rx_valid, tx_pop, busy, addressed, rd_mode, rx_overrun, tx_underrun, rx_data},
              '0);
        arst_n = 1'b1;
        tick(5);

        dbuf[0] = 8'hA5; dbuf[1] = 8'h3C; rdy[0] = 1; rdy[1] = 1;
        xfer(7'h50, 1'b0, 2, 1'b1);
        dbuf[0] = 8'h99; rdy[0] = 1;
        xfer(7'h51, 1'b0, 1, 1'b1);
        dbuf[0] = 8'h81; dbuf[1] = 8'h7E; txv[0] = 1; txv[1] = 1;
        xfer(7'h50, 1'b1, 2, 1'b1);
        chk_counts("read2");
        dbuf[0] = 8'h11; rdy[0] = 1;
        xfer(7'h50, 1'b0, 1, 1'b0);
        dbuf[0] = 8'h5A; txv[0] = 1;
        xfer(7'h50, 1'b1, 1, 1'b1);
        dbuf[0] = 8'h12; dbuf[1] = 8'h34; rdy[0] = 1; rdy[1] = 0;
        xfer(7'h50, 1'b0, 2, 1'b1);
        chk_counts("overrun");
        dbuf[0] = 8'h77; txv[0] = 0;
        xfer(7'h50, 1'b1, 1, 1'b1);
        chk_counts("underrun");

        // Reset in the middle of a read byte while the target pulls SDA low.
        tx_valid = 1'b1; tx_data = 8'h00;
        exp_bus.push_back({7'h50, 1'b1, 1'b0});
        exp_pop++;
        m_start;
        m_wbyte({7'h50, 1'b1});
        m_rbit(ab);
        for (int i = 0; i < 3; i++) m_rbit(ab);
        check("oe_before_reset", sda_oe, 1'b1);
        arst_n = 1'b0;
        #1;
        check("oe_async_reset", sda_oe, 1'b0);
        check("busy_async_reset", busy, 1'b0);
        tick(3);
        arst_n = 1'b1;
        tx_valid = 1'b0;
        tick(2);
        dbuf[0] = 8'hC3; rdy[0] = 1;
        xfer(7'h50, 1'b0, 1, 1'b1);
        chk_counts("after_reset");

        for (int t = 0; t < 16; t++) begin
            if ($urandom_range(0, 3) == 0) own_addr = 7'($urandom);
            case ($urandom_range(0, 3))
                0:       a = own_addr ^ 7'h01;
                1:       a = 7'($urandom);
                default: a = own_addr;
            endcase
            rw = 1'($urandom);
            n  = $urandom_range(1, 3);
            for (int i = 0; i < n; i++) begin
                dbuf[i] = 8'($urandom);
                rdy[i]  = ($urandom_range(0, 7) != 0);
                txv[i]  = ($urandom_range(0, 7) != 0);
            end
            st = (t == 15) || ($urandom_range(0, 3) != 0);
            xfer(a, rw, n, st);
        end

        tick(20);
        check("bus_queue_drained", exp_bus.size(), 0);
        check("rx_queue_drained", exp_rx.size(), 0);
        chk_counts("final");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/i2c_target.md
Name: i2c_target

Overview:
- I2C target (slave) engine: the responder for the team's I2C master controller.
- Sits behind the pad ring; samples SCL/SDA and drives SDA open-drain through an output-enable.
- Received write bytes go out on a valid/ready stream; read bytes come in on a valid/pop stream.
- Used for loopback verification of the master and as a target peripheral for an external host. 7-bit addressing only; no general call or 10-bit addressing.

Parameters:
DATA_BITS, 8, byte width (fixed by protocol; present only for consistency)
SYNC_STAGES, 2, flops in the SCL/SDA input synchronizers (minimum 2)

Ports:
clk  input  1  system clock; must be at least 8x the SCL frequency
arst_n  input  1  asynchronous active-low reset
own_addr  input  7  target address; sampled when the address byte completes
scl_i  input  1  raw SCL pad input
sda_i  input  1  raw SDA pad input
sda_oe  output  1  1 = pull SDA low; 0 = release (high-Z)
scl_oe  output  1  1 = hold SCL low (clock stretch); tied 0 without the optional feature
rx_data  output  8  received write byte
rx_valid  output  1  one-cycle pulse: rx_data is valid
rx_ready  input  1  sink can accept a byte; sampled in the rx_valid cycle
tx_data  input  8  byte to return on a read
tx_valid  input  1  tx_data is available
tx_pop  output  1  one-cycle pulse: tx_data consumed
busy  output  1  high from START to STOP, whether or not this target is addressed
addressed  output  1  high while this target is selected in the current transfer
rd_mode  output  1  R/W bit of the current transaction (1 = read)
rx_overrun  output  1  one-cycle pulse: write byte NACKed because rx_ready was 0
tx_underrun  output  1  one-cycle pulse: read byte started with tx_valid = 0

Behaviour:
- Reset: all outputs 0; FSM in IDLE; synchronizer flops reset to 1 (bus released).
- Edge detection:
  - Synchronized SCL and SDA are each registered once more.
  - rise/fall are single-cycle strobes.
  - START = SDA fall while SCL high. STOP = SDA rise while SCL high. Both are checked before any data event in the same cycle.
- START (including repeated START) in any state: go to ADDR, clear the bit counter, release sda_oe, set busy.
- STOP in any state: go to IDLE, clear busy/addressed/rd_mode, release sda_oe.
- FSM states: IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP.
- ADDR:
  - Shift SDA on each SCL rise, MSB first, for 8 bits (7-bit address + R/W).
  - On the 8th rise: if address == own_addr, go to ADDR_ACK with rd_mode latched and addressed = 1; otherwise go to WAIT_STOP.
- ADDR_ACK:
  - On the next SCL fall, assert sda_oe.
  - Hold sda_oe through the 9th SCL rise.
  - On the following fall: release sda_oe and go to WR_DATA (write) or RD_DATA (read).
- WR_DATA:
  - Shift 8 bits on SCL rises.
  - On the 8th rise: drive rx_data and pulse rx_valid one cycle later.
  - If rx_ready = 1 in that cycle, ACK: WR_ACK drives sda_oe as in ADDR_ACK.
  - Otherwise NACK: pulse rx_overrun, drop the byte, leave SDA released for the ACK clock, then go to WAIT_STOP.
- RD_DATA:
  - On entry (at the SCL fall), load the shifter from tx_data and pulse tx_pop, but only if tx_valid = 1.
  - If tx_valid = 0: load 0xFF and pulse tx_underrun. tx_pop is not pulsed.
  - Each bit is output on the SCL fall, MSB first: sda_oe = ~bit. Bit 7 is driven at entry.
  - After the 8th bit, release SDA at the SCL fall and go to RD_ACK.
- RD_ACK:
  - Sample SDA on the 9th SCL rise.
  - 0 (master ACK): go to RD_DATA at the next fall.
  - 1 (master NACK): go to WAIT_STOP with SDA released.
- WAIT_STOP: SDA released; exits only on STOP or START.
- sda_oe changes only in the cycle after a detected SCL fall, never while SCL is high. This keeps the hold time ≥ 1 clk plus the synchronizer delay.
- Reset asserted mid-transfer: immediate release of SDA/SCL; the next bus START is detected normally.

Optional Feature:
- I2C_TARGET_STRETCH_EN defined:
  - Entering RD_DATA with tx_valid = 0: assert scl_oe (hold SCL low) until tx_valid = 1, then load, pulse tx_pop and release scl_oe. tx_underrun never pulses.
  - WR_DATA with rx_ready = 0 at byte end: hold rx_valid/rx_data and assert scl_oe until rx_ready = 1, then ACK. rx_overrun never pulses.
- Undefined: scl_oe is tied 0; underrun/overrun behave as described in Behaviour.

Test Plan:
- own_addr=0x50; master writes addr 0x50/W, then 0xA5 and 0x3C, then STOP, rx_ready=1 → both ACKs low; rx_valid pulses with 0xA5 then 0x3C; busy falls at STOP.
- Master addresses 0x51 while own_addr=0x50 → sda_oe stays 0 for the whole transfer; no rx_valid; addressed stays 0; FSM in WAIT_STOP until STOP.
- Read from 0x50 with tx stream 0x81, 0x7E; master ACKs byte 1 and NACKs byte 2 → bus carries 0x81, 0x7E; exactly two tx_pop pulses; FSM in WAIT_STOP, then IDLE at STOP.
- Write 0x50/W, data 0x11, repeated START, read 0x50/R → rx 0x11 received; rd_mode goes 0→1; addressed stays 1; tx byte driven correctly.
- Write with rx_ready=0 on byte 2 (no macro) → ACK on byte 1, NACK on byte 2, one rx_overrun pulse. With the macro: SCL held low until rx_ready=1, then ACK.
- Read with tx_valid=0 (no macro) → 0xFF on the bus, one tx_underrun pulse, no tx_pop; arst_n pulsed mid-byte → sda_oe=0 immediately and the next START is recognised.
